sr_block_accumulator: RTL and testbench

//  Consumer of the stochastic-rounding output stream: accepts signed fixed-point

---
 rtl/sr_block_accumulator.sv | 116 +++++++++++
 tb/tb_sr_block_accumulator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sr_block_accumulator.sv
// Block accumulator for stochastically rounded samples: sums BLOCK_LEN accepted
// samples with per-add saturation and hands each block sum out on valid/ready.
module sr_block_accumulator #(
    parameter int IN_W      = 10,
    parameter int ACC_W     = 20,
    parameter int BLOCK_LEN = 16,
    parameter int CNT_W     = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [ACC_W-1:0] out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sat,
    output logic [CNT_W-1:0]        count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    sat_acc_q, sat_acc_d;
    logic signed [ACC_W-1:0] out_q, out_d;
    logic                    out_sat_q, out_sat_d;

    logic [ACC_W:0]          sum_wide;
    logic signed [ACC_W-1:0] sum_sat;
    logic                    clamp;
    logic                    accept;
    logic                    transfer;

    // One guard bit is enough: a single add of two in-range values cannot
    // overflow ACC_W+1 bits, so the top two bits disagreeing means out of range.
    always_comb begin
        sum_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-IN_W){in[IN_W-1]}}, in};
        clamp    = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        if (clamp) begin
            sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat = sum_wide[ACC_W-1:0];
        end
    end

    assign accept   = in_valid && (state_q == ST_ACCUM);
    assign transfer = out_ready && (state_q == ST_HOLD);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        sat_acc_d = sat_acc_q;
        out_d     = out_q;
        out_sat_d = out_sat_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (count_q == LAST_IDX) begin
                        out_d     = sum_sat;
                        out_sat_d = sat_acc_q | clamp;
                        acc_d     = '0;
                        count_d   = '0;
                        sat_acc_d = 1'b0;
                        state_d   = ST_HOLD;
                    end else begin
                        acc_d     = sum_sat;
                        count_d   = count_q + CNT_W'(1);
                        sat_acc_d = sat_acc_q | clamp;
                    end
                end
            end
            ST_HOLD: begin
                // out/out_sat deliberately keep their value after the handoff
                if (transfer) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACCUM;
            acc_q     <= '0;
            count_q   <= '0;
            sat_acc_q <= 1'b0;
            out_q     <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            sat_acc_q <= sat_acc_d;
            out_q     <= out_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign out       = out_q;
    assign out_sat   = out_sat_q;
    assign count     = count_q;

endmodule

// File: tb/tb_sr_block_accumulator.sv
// Bench for sr_block_accumulator: two instances (20-bit and 12-bit accumulators)
// share stimulus and are compared against a queue-based block-sum model.
module tb_sr_block_accumulator;

    localparam int IN_W  = 10;
    localparam int CNT_W = 5;
    localparam int BL    = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [IN_W-1:0] in_s;
    logic            in_valid;
    logic            out_ready;

    logic            in_ready_a, out_valid_a, out_sat_a;
    logic [19:0]     out_a;
    logic [CNT_W-1:0] count_a;
    logic            in_ready_b, out_valid_b, out_sat_b;
    logic [11:0]     out_b;
    logic [CNT_W-1:0] count_b;

    sr_block_accumulator #(.IN_W(IN_W), .ACC_W(20), .BLOCK_LEN(BL), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst(rst), .in(in_s), .in_valid(in_valid), .in_ready(in_ready_a),
        .out(out_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sat(out_sat_a), .count(count_a)
    );

    sr_block_accumulator #(.IN_W(IN_W), .ACC_W(12), .BLOCK_LEN(BL), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst(rst), .in(in_s), .in_valid(in_valid), .in_ready(in_ready_b),
        .out(out_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sat(out_sat_b), .count(count_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: samples of the open block, plus the last completed block.
    int q[$];
    bit m_valid;
    int m_out_a, m_out_b;
    bit m_sat_a, m_sat_b;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic void block_sum(input int w, output int s, output bit sat);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        s   = 0;
        sat = 1'b0;
        foreach (q[i]) begin
            s = s + q[i];
            if (s > hi) begin
                s = hi; sat = 1'b1;
            end else if (s < lo) begin
                s = lo; sat = 1'b1;
            end
        end
    endfunction

    task automatic check_all();
        chk("in_ready_a", int'(in_ready_a), int'(!m_valid));
        chk("in_ready_b", int'(in_ready_b), int'(!m_valid));
        chk("out_valid_a", int'(out_valid_a), int'(m_valid));
        chk("out_valid_b", int'(out_valid_b), int'(m_valid));
        chk("count_a", int'(count_a), q.size());
        chk("count_b", int'(count_b), q.size());
        chk("out_a", int'($signed(out_a)), m_out_a);
        chk("out_b", int'($signed(out_b)), m_out_b);
        chk("out_sat_a", int'(out_sat_a), int'(m_sat_a));
        chk("out_sat_b", int'(out_sat_b), int'(m_sat_b));
    endtask

    task automatic cycle(input bit v, input int x, input bit ordy);
        bit accept, xfer;
        int xs;
        logic [IN_W-1:0] xb;
        xb        = x[IN_W-1:0];
        in_valid  = v;
        in_s      = xb;
        out_ready = ordy;
        xs        = int'($signed(xb));
        accept    = v && !m_valid;
        xfer      = m_valid && ordy;
        @(posedge clk);
        #1;
        if (xfer) m_valid = 1'b0;
        if (accept) begin
            q.push_back(xs);
            if (q.size() == BL) begin
                block_sum(20, m_out_a, m_sat_a);
                block_sum(12, m_out_b, m_sat_b);
                m_valid = 1'b1;
                q.delete();
            end
        end
        check_all();
    endtask

    task automatic do_reset(input bit v, input int x);
        rst       = 1'b1;
        in_valid  = v;
        in_s      = x[IN_W-1:0];
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_valid = 1'b0;
        m_out_a = 0; m_out_b = 0;
        m_sat_a = 1'b0; m_sat_b = 1'b0;
        check_all();
    endtask

    typedef struct {
        int v1; int n1; int v2; int n2;
        int ea; bit sa; int eb; bit sb;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int held_a;
        int acc_n;
        tbl[0] = '{256, 16, 0, 0, 4096, 1'b0, 2047, 1'b1};
        tbl[1] = '{-256, 8, 500, 8, 1952, 1'b0, 1952, 1'b0};
        tbl[2] = '{-100, 16, 0, 0, -1600, 1'b0, -1600, 1'b0};
        tbl[3] = '{255, 16, 0, 0, 4080, 1'b0, 2047, 1'b1};
        tbl[4] = '{-1, 16, 0, 0, -16, 1'b0, -16, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_s = '0; out_ready = 1'b0;
        do_reset(1'b0, 0);
        do_reset(1'b0, 0);

        // Table-driven blocks, out_ready held high throughout
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < tbl[i].n1; k++) cycle(1'b1, tbl[i].v1, 1'b1);
            for (int k = 0; k < tbl[i].n2; k++) cycle(1'b1, tbl[i].v2, 1'b1);
            chk("tbl_valid", int'(out_valid_a), 1);
            chk("tbl_ready_low", int'(in_ready_a), 0);
            chk("tbl_out_a", int'($signed(out_a)), tbl[i].ea);
            chk("tbl_sat_a", int'(out_sat_a), int'(tbl[i].sa));
            chk("tbl_out_b", int'($signed(out_b)), tbl[i].eb);
            chk("tbl_sat_b", int'(out_sat_b), int'(tbl[i].sb));
            cycle(1'b1, 0, 1'b1);
            chk("tbl_valid_drop", int'(out_valid_a), 0);
            chk("tbl_out_kept", int'($signed(out_a)), tbl[i].ea);
        end

        // Back-pressure: block held for 5 cycles while in_valid stays high
        for (int k = 0; k < BL; k++) cycle(1'b1, 10, 1'b0);
        held_a = int'($signed(out_a));
        chk("bp_out", held_a, 160);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 77, 1'b0);
            chk("bp_stable", int'($signed(out_a)), 160);
            chk("bp_count", int'(count_a), 0);
        end
        cycle(1'b0, 0, 1'b1);
        chk("bp_released", int'(in_ready_a), 1);

        // Reset mid-block discards the partial sum
        for (int k = 0; k < 7; k++) cycle(1'b1, 500, 1'b1);
        chk("pre_rst_count", int'(count_a), 7);
        do_reset(1'b1, 500);
        chk("post_rst_count", int'(count_a), 0);
        for (int k = 0; k < BL; k++) cycle(1'b1, 1, 1'b0);
        chk("rst_block_out", int'($signed(out_a)), 16);
        cycle(1'b0, 0, 1'b1);

        // Gappy in_valid
        acc_n = 0;
        for (int c = 0; c < 300 && acc_n < BL; c++) begin
            bit v;
            v = 1'(($urandom_range(0, 1)));
            if (v && !m_valid) acc_n++;
            cycle(v, 100, 1'b0);
        end
        chk("gap_accepts", acc_n, BL);
        chk("gap_out", int'($signed(out_a)), 1600);
        cycle(1'b0, 0, 1'b1);

        // Random traffic against the model
        for (int c = 0; c < 800; c++) begin
            bit v, r;
            int x;
            v = 1'(($urandom_range(0, 3) != 0));
            r = 1'(($urandom_range(0, 1)));
            x = int'($urandom_range(0, 1023)) - 512;
            if ((c % 200) < 60) x = (x < 0) ? -500 : 500;
            cycle(v, x, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
